// File: rtl/pool_nxn_stream.sv
// pool_nxn_stream: streaming non-overlapping POOL x POOL signed max/average pooling
// over raster-ordered samples, with row/column counters and frame realignment on in_sof.
module pool_nxn_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int POOL   = 2,
    parameter int MODE   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    input  logic                     in_sof,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_vld,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_eof
);
    localparam int LP = $clog2(POOL);
    localparam int NK = IMG_W / POOL;
    localparam int KW = NK > 1 ? $clog2(NK) : 1;
    localparam int AW = MODE != 0 ? DATA_W + 2 * LP : DATA_W;
    localparam int SH = MODE != 0 ? 2 * LP : 0;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    logic signed [AW-1:0] r_acc [NK];

    logic [CW-1:0]        w_col;
    logic [RW-1:0]        w_row;
    logic [KW-1:0]        w_k;
    logic                 w_first;
    logic                 w_last;
    logic                 w_col_end;
    logic                 w_row_end;
    logic signed [AW-1:0] w_ext;
    logic signed [AW-1:0] w_cur;
    logic signed [AW-1:0] w_comb;
    logic signed [AW-1:0] w_shift;

    // in_sof forces the beat to pixel (0,0), which also abandons any open windows
    assign w_col     = in_sof ? '0 : r_col;
    assign w_row     = in_sof ? '0 : r_row;
    assign w_k       = KW'(w_col >> LP);
    assign w_first   = ~|w_col[LP-1:0] & ~|w_row[LP-1:0];
    assign w_last    = &w_col[LP-1:0] & &w_row[LP-1:0];
    assign w_col_end = w_col == COL_MAX;
    assign w_row_end = w_row == ROW_MAX;
    assign w_ext     = AW'(in_data);
    assign w_cur     = r_acc[w_k];
    assign w_comb    = w_first ? w_ext : MODE != 0 ? w_cur + w_ext : (w_ext > w_cur ? w_ext : w_cur);
    assign w_shift   = w_comb >>> SH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col    <= '0;
            r_row    <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_eof  <= 1'b0;
            for (int i = 0; i < NK; i++) r_acc[i] <= '0;
        end else begin
            out_vld <= in_vld & w_last;
            out_eof <= in_vld & w_last & w_col_end & w_row_end;
            if (in_vld) begin
                r_acc[w_k] <= w_comb;
                r_col      <= w_col_end ? '0 : w_col + 1'b1;
                r_row      <= w_col_end ? (w_row_end ? '0 : w_row + 1'b1) : w_row;
                if (w_last) out_data <= w_shift[DATA_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_pool_nxn_stream.sv
// tb_pool_nxn_stream: scoreboard bench driving a max-mode and an average-mode
// instance with the same 4x4 stream and checking value, eof and one-cycle latency.
module tb_pool_nxn_stream;
    typedef int frame_t [4][4];
    typedef struct {
        int data;
        int eof;
        int due;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_vld;
    logic              in_sof;
    logic signed [7:0] in_data;
    logic              mx_vld, mx_eof, av_vld, av_eof;
    logic signed [7:0] mx_data, av_data;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q_mx[$];
    exp_t q_av[$];

    frame_t fa = '{'{1, 5, -3, 2}, '{4, -7, 8, 0}, '{-1, -2, -3, -4}, '{9, 0, 0, -5}};
    frame_t fb = '{'{-1, -2, 127, 127}, '{-3, -4, 127, 127}, '{-128, -128, 1, 2}, '{-128, -128, 2, 2}};

    pool_nxn_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .POOL(2), .MODE(0)) u_mx (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_sof(in_sof), .in_data(in_data),
        .out_vld(mx_vld), .out_data(mx_data), .out_eof(mx_eof)
    );

    pool_nxn_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .POOL(2), .MODE(1)) u_av (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_sof(in_sof), .in_data(in_data),
        .out_vld(av_vld), .out_data(av_data), .out_eof(av_eof)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives the first n beats of a frame; expectations come from a window model of the frame.
    task automatic send_frame(input frame_t f, input bit sof, input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            int r = i / 4;
            int c = i % 4;
            repeat ($urandom_range(0, maxgap)) begin
                @(negedge clk);
                in_vld  = 1'b0;
                in_sof  = 1'($urandom_range(0, 1));
                in_data = 8'($urandom);
            end
            @(negedge clk);
            in_vld  = 1'b1;
            in_sof  = sof && i == 0;
            in_data = 8'(f[r][c]);
            if (r % 2 == 1 && c % 2 == 1) begin
                int mx = f[r][c];
                int s = 0;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++) begin
                        s += f[r-dr][c-dc];
                        if (f[r-dr][c-dc] > mx) mx = f[r-dr][c-dc];
                    end
                q_mx.push_back('{mx, int'(i == 15), cyc + 1});
                q_av.push_back('{s >>> 2, int'(i == 15), cyc + 1});
            end
        end
    endtask

    always @(negedge clk) if (!rst) begin
        if (mx_vld) begin
            check("mx_unexpected_out", int'(q_mx.size() != 0), 1);
            if (q_mx.size() != 0) begin
                exp_t e;
                e = q_mx.pop_front();
                check("mx_data", mx_data, e.data);
                check("mx_eof", mx_eof, e.eof);
                check("mx_latency", cyc, e.due);
            end
        end else check("mx_eof_idle", mx_eof, 0);
    end

    always @(negedge clk) if (!rst) begin
        if (av_vld) begin
            check("av_unexpected_out", int'(q_av.size() != 0), 1);
            if (q_av.size() != 0) begin
                exp_t e;
                e = q_av.pop_front();
                check("av_data", av_data, e.data);
                check("av_eof", av_eof, e.eof);
                check("av_latency", cyc, e.due);
            end
        end else check("av_eof_idle", av_eof, 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_sof  = 1'b0;
        in_data = '0;
        repeat (2) @(negedge clk);
        check("rst_mx_vld", mx_vld, 0);
        check("rst_mx_data", mx_data, 0);
        check("rst_mx_eof", mx_eof, 0);
        check("rst_av_vld", av_vld, 0);
        check("rst_av_data", av_data, 0);
        check("rst_av_eof", av_eof, 0);
        rst = 1'b0;
        // frame with sof, then two back-to-back frames without sof
        send_frame(fa, 1'b1, 16, 0);
        send_frame(fa, 1'b0, 16, 0);
        send_frame(fa, 1'b0, 16, 0);
        // average-mode boundary windows
        send_frame(fb, 1'b0, 16, 0);
        // idle gaps, including inside windows
        send_frame(fa, 1'b0, 16, 3);
        // aborted partial frame followed by resync
        send_frame(fa, 1'b0, 5, 0);
        send_frame(fa, 1'b1, 16, 0);
        // asynchronous reset while out_vld is high
        send_frame(fa, 1'b0, 6, 0);
        @(negedge clk);
        in_vld = 1'b0;
        in_sof = 1'b0;
        #2;
        check("pre_rst_mx_vld", mx_vld, 1);
        check("pre_rst_mx_data", mx_data, 5);
        rst = 1'b1;
        #1;
        check("async_rst_mx_vld", mx_vld, 0);
        check("async_rst_mx_data", mx_data, 0);
        check("async_rst_mx_eof", mx_eof, 0);
        check("async_rst_av_vld", av_vld, 0);
        check("async_rst_av_data", av_data, 0);
        check("async_rst_av_eof", av_eof, 0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(fa, 1'b0, 16, 0);
        @(negedge clk);
        in_vld = 1'b0;
        in_sof = 1'b0;
        repeat (4) @(negedge clk);
        check("mx_outputs_missing", q_mx.size(), 0);
        check("av_outputs_missing", q_av.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
